stopwatch_core: RTL



---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/bcd_mod_counter.sv | 45 ++++
 rtl/stopwatch_core.sv | 132 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping stage.
// Holds the FSM state encoding, disp_bcd field layout and BCD limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    // LSB of each two-digit field inside disp_bcd
    localparam int CC_LSB = 0;
    localparam int SS_LSB = 8;
    localparam int MM_LSB = 16;
    localparam int HH_LSB = 24;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX6 = 4'd5;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD (60 or 100).
// carry_out is combinational so a chain ripples within one tick.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry_out
);

    localparam int         TENS_LIM = MOD / 10 - 1;
    localparam logic [3:0] TENS_MAX = (MOD == 60) ? BCD_TENS_MAX6
                                                  : TENS_LIM[3:0];

    logic [3:0] tens_q;
    logic [3:0] units_q;
    logic       at_max;

    assign at_max    = (tens_q == TENS_MAX) && (units_q == BCD_MAX);
    assign carry_out = inc && at_max;
    assign tens      = tens_q;
    assign units     = units_q;

    // Digit pair update: units roll into tens, tens roll to zero at MOD
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens_q  <= '0;
            units_q <= '0;
        end else if (inc) begin
            if (units_q == BCD_MAX) begin
                units_q <= '0;
                tens_q  <= (tens_q == TENS_MAX) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_q <= units_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: centisecond prescaler, HH:MM:SS.CC BCD cascade,
// run/pause/lap/clear FSM and registered display word.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop_p,
    input  logic        lap_p,
    input  logic        clear_p,
    output logic [31:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);

    localparam int            DIV       = calc_div(CLK_HZ, TICK_HZ);
    localparam int            PW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    sw_state_t     state;
    sw_state_t     state_nx;
    logic          snap_en;
    logic          clr_cnt;
    logic          counting;
    logic          tick;
    logic [PW-1:0] presc;
    logic [31:0]   live;
    logic [31:0]   snapshot;

    logic [3:0] cc_t, cc_u, ss_t, ss_u, mm_t, mm_u, hh_t, hh_u;
    logic       cc_co, ss_co, mm_co, hh_co;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state; ignored pulses do not block lower-priority ones
    always_comb begin
        state_nx = state;
        snap_en  = 1'b0;
        clr_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_stop_p) state_nx = RUN;
            end
            RUN: begin
                if (start_stop_p) begin
                    state_nx = PAUSE;
                end else if (lap_p) begin
                    state_nx = LAP;
                    snap_en  = 1'b1;
                end
            end
            LAP: begin
                if (start_stop_p) state_nx = PAUSE;
                else if (lap_p)   state_nx = RUN;
            end
            PAUSE: begin
                if (clear_p) begin
                    state_nx = IDLE;
                    clr_cnt  = 1'b1;
                end else if (start_stop_p) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_MAX);

    // Prescaler holds while paused so the partial tick survives
    always_ff @(posedge clk) begin
        if (rst || clr_cnt)  presc <= '0;
        else if (counting)   presc <= tick ? '0 : presc + 1'b1;
    end

    bcd_mod_counter #(.MOD(100)) u_cc (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(tick),
        .tens(cc_t), .units(cc_u), .carry_out(cc_co)
    );

    bcd_mod_counter #(.MOD(60)) u_ss (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(cc_co),
        .tens(ss_t), .units(ss_u), .carry_out(ss_co)
    );

    bcd_mod_counter #(.MOD(60)) u_mm (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(ss_co),
        .tens(mm_t), .units(mm_u), .carry_out(mm_co)
    );

    bcd_mod_counter #(.MOD(100)) u_hh (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(mm_co),
        .tens(hh_t), .units(hh_u), .carry_out(hh_co)
    );

    assign live[HH_LSB +: 8] = {hh_t, hh_u};
    assign live[MM_LSB +: 8] = {mm_t, mm_u};
    assign live[SS_LSB +: 8] = {ss_t, ss_u};
    assign live[CC_LSB +: 8] = {cc_t, cc_u};

    // Lap snapshot takes the pre-increment count of the lap cycle
    always_ff @(posedge clk) begin
        if (rst)          snapshot <= '0;
        else if (snap_en) snapshot <= live;
    end

    // Registered outputs; status flags decode the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd   <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            disp_bcd   <= (state == LAP) ? snapshot : live;
            running    <= (state_nx == RUN) || (state_nx == LAP);
            lap_active <= (state_nx == LAP);
            if (clr_cnt)    ovf <= 1'b0;
            else if (hh_co) ovf <= 1'b1;
        end
    end

endmodule
